router_merge_4to1: RTL
======================

Name: router_merge_4to1

Overview:
- Four-input to one-output packet merger; the return-path counterpart of the 1-to-4 address router.
- Four upstream sources present beats with valid/ready handshakes.
- A round-robin arbiter picks one source and locks onto it until that packet's last beat transfers.
- Each beat is forwarded through a single output register, tagged with the 2-bit source address so the downstream consumer can recover the origin.

Parameters:
- DATA_WIDTH, 32, width of every data bus.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- resetn  input  1  asynchronous active-low reset.
- din0  input  DATA_WIDTH  source 0 data.
- din1  input  DATA_WIDTH  source 1 data.
- din2  input  DATA_WIDTH  source 2 data.
- din3  input  DATA_WIDTH  source 3 data.
- din_en  input  4  per-source beat valid; bit i belongs to din<i>.
- din_last  input  4  per-source last-beat-of-packet flag; qualified by din_en[i].
- din_rdy  output  4  per-source ready; a beat transfers when din_en[i] and din_rdy[i] are both 1.
- dout  output  DATA_WIDTH  merged data.
- dout_en  output  1  output beat valid.
- dout_last  output  1  last beat of the output packet.
- dout_addr  output  2  source index of the current output beat.
- dout_rdy  input  1  downstream ready.

Behaviour:
- Reset (asynchronous, resetn=0):
  - dout=0, dout_en=0, dout_last=0, dout_addr=0.
  - FSM goes to IDLE; round-robin pointer rr_ptr=0.
  - din_rdy=0 while reset is asserted.
- Output register:
  - out_free = ~dout_en | dout_rdy.
  - When a beat is accepted, it loads dout/dout_last/dout_addr and sets dout_en=1 on the next edge. Latency is exactly 1 cycle from input transfer to dout_en.
  - If dout_en=1 and dout_rdy=0, all output signals hold stable.
  - If the register drains (dout_en & dout_rdy) with no new beat accepted that cycle, next cycle dout_en=0 and dout, dout_last, dout_addr are forced to 0.
  - Full throughput: one beat per cycle while dout_rdy=1.
- FSM states: IDLE, LOCKED. Register owner[1:0] holds the locked source.
- IDLE:
  - Winner = first i with din_en[i]=1, searching i = rr_ptr, rr_ptr+1, ... modulo 4.
  - din_rdy[winner] = out_free; all other din_rdy = 0.
  - On transfer with din_last=1: stay IDLE, rr_ptr <= winner+1 (mod 4, 2-bit wrap).
  - On transfer with din_last=0: go to LOCKED, owner <= winner.
  - No din_en set: din_rdy = 0, stay IDLE.
- LOCKED:
  - din_rdy[owner] = out_free; all other din_rdy = 0.
  - din_en of non-owners is ignored; their requests wait.
  - On owner transfer with din_last=1: go to IDLE, rr_ptr <= owner+1.
  - Owner din_en=0 (bubble): stay LOCKED, no transfer.
- rr_ptr changes only on packet completion. A single-beat packet counts as a complete packet.
- din_rdy is combinational from state, rr_ptr, din_en and out_free. It does not depend on din_last.
- Upstream rule: a source holds din_en/din/din_last stable until its beat transfers. The block need not detect violations.
- Reset mid-packet: the partial packet is abandoned and the output register cleared. After release, arbitration restarts from source 0.

Optional Feature:
- Macro: ROUTER_MERGE_FIXED_PRIO_EN.
- Defined: IDLE arbitration is fixed priority, lowest index wins (source 0 highest). rr_ptr is removed and packet locking is unchanged.
- Undefined: round-robin as specified above.

Test Plan:
- Reset: drive resetn=0 mid-traffic -> dout=0, dout_en=0, dout_addr=0, din_rdy=4'b0000 immediately. After release, source 2 single beat 0xA5A5A5A5 with last=1 -> next cycle dout=0xA5A5A5A5, dout_addr=2, dout_last=1.
- Round-robin: all four sources hold single-beat packets 0x10,0x11,0x12,0x13, dout_rdy=1 -> dout_addr sequence 0,1,2,3 on consecutive cycles, then 0 again if source 0 re-requests.
- Lock: source 1 sends 3-beat packet 0x100,0x101,0x102 (last on third) while source 0 requests -> din_rdy[0]=0 until 0x102 transfers. Output shows 1,1,1 then 0.
- Backpressure: dout_rdy=0 for 3 cycles with dout_en=1 -> dout/dout_addr/dout_last unchanged, din_rdy all 0. Releasing dout_rdy resumes at one beat per cycle with no loss or duplication.
- Bubble in packet: owner 3 drops din_en for 2 cycles mid-packet while source 0 requests -> no source-0 beat appears until source 3's last beat transfers; dout_en=0 and dout=0 during the bubble.
- ROUTER_MERGE_FIXED_PRIO_EN defined: sources 0 and 2 continuously request single-beat packets -> dout_addr stays 0 every cycle, source 2 is never granted.

Source files
------------

// File: rtl/router_merge_4to1.sv
// Merges four valid/ready beat streams into one registered output, locking onto a source for a whole packet.
// Latency: one cycle from an input transfer to dout_en; full throughput while dout_rdy is high.
// Backpressure: dout_rdy=0 with dout_en=1 freezes the output register and drops every din_rdy.
// Optional ROUTER_MERGE_FIXED_PRIO_EN replaces the round-robin pointer with fixed lowest-index priority.
module router_merge_4to1 #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] din1,
  input  logic [DATA_WIDTH-1:0] din2,
  input  logic [DATA_WIDTH-1:0] din3,
  input  logic [3:0]            din_en,
  input  logic [3:0]            din_last,
  output logic [3:0]            din_rdy,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_en,
  output logic                  dout_last,
  output logic [1:0]            dout_addr,
  input  logic                  dout_rdy
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [1:0]            owner_q;
  logic                  out_free;
  logic                  win_vld;
  logic [1:0]            win_idx;
  logic                  grant_vld;
  logic [1:0]            grant_idx;
  logic                  xfer;
  logic [DATA_WIDTH-1:0] sel_dat;
  logic                  sel_last;

  assign out_free = ~dout_en | dout_rdy;

`ifdef ROUTER_MERGE_FIXED_PRIO_EN
  always_comb begin
    win_vld = 1'b0;
    win_idx = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (din_en[k]) begin
        win_vld = 1'b1;
        win_idx = 2'(k);
      end
    end
  end
`else
  logic [1:0] rr_ptr_q;
  logic [7:0] en_dbl;
  logic [3:0] en_rot;
  logic [1:0] rot_off;

  // Rotate requests so the pointer position becomes bit 0, then pick the lowest set bit.
  always_comb begin
    en_dbl  = {din_en, din_en};
    en_rot  = en_dbl[rr_ptr_q +: 4];
    win_vld = |en_rot;
    rot_off = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (en_rot[k]) begin
        rot_off = 2'(k);
      end
    end
    win_idx = rr_ptr_q + rot_off;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rr_ptr_q <= 2'd0;
    end else if (xfer && sel_last) begin
      rr_ptr_q <= grant_idx + 2'd1;
    end
  end
`endif

  // Source that may transfer this cycle: the locked owner, otherwise the arbitration winner.
  always_comb begin
    if (state_q == ST_LOCKED) begin
      grant_idx = owner_q;
      grant_vld = din_en[owner_q];
    end else begin
      grant_idx = win_idx;
      grant_vld = win_vld;
    end
  end

  always_comb begin
    case (grant_idx)
      2'd0:    sel_dat = din0;
      2'd1:    sel_dat = din1;
      2'd2:    sel_dat = din2;
      default: sel_dat = din3;
    endcase
    sel_last = din_last[grant_idx];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (xfer && !sel_last) state_d = ST_LOCKED;
      ST_LOCKED: if (xfer && sel_last)  state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Ready is gated by resetn so nothing handshakes while the block is held in reset.
  always_comb begin
    din_rdy = 4'b0000;
    xfer    = resetn & grant_vld & out_free;
    if (xfer) begin
      din_rdy[grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      owner_q <= 2'd0;
    end else if (state_q == ST_IDLE && xfer && !sel_last) begin
      owner_q <= grant_idx;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dout      <= '0;
      dout_en   <= 1'b0;
      dout_last <= 1'b0;
      dout_addr <= 2'd0;
    end else if (xfer) begin
      dout      <= sel_dat;
      dout_en   <= 1'b1;
      dout_last <= sel_last;
      dout_addr <= grant_idx;
    end else if (dout_en && dout_rdy) begin
      dout      <= '0;
      dout_en   <= 1'b0;
      dout_last <= 1'b0;
      dout_addr <= 2'd0;
    end
  end

endmodule
